// File: rtl/chnl_tester_pkg.sv
// Shared definitions for the RIFFA channel tester: mode codes, FSM states
// and the word-length to beat-count conversion.
package chnl_tester_pkg;

  localparam logic [1:0] MODE_LOOP = 2'd0;
  localparam logic [1:0] MODE_INC  = 2'd1;
  localparam logic [1:0] MODE_PAT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_RUN,
    ST_FINISH
  } state_e;

  // Round a length in 32-bit words up to whole channel beats (32-bit wrap).
  function automatic logic [31:0] beats_of(input logic [31:0] len, input int unsigned width);
    logic [31:0] n;
    case (width)
      64:      n = (len + 32'd1) >> 1;
      128:     n = (len + 32'd3) >> 2;
      default: n = len;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/riffa_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout_o shows the oldest entry
// whenever empty_o is low.
module riffa_sync_fifo #(
  parameter int unsigned C_WIDTH      = 32,
  parameter int unsigned C_DEPTH_LOG2 = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               push_i,
  input  logic [C_WIDTH-1:0] din_i,
  input  logic               pop_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [C_WIDTH-1:0] dout_o
);

  localparam int unsigned DEPTH = 2 ** C_DEPTH_LOG2;
  localparam logic [C_DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [C_DEPTH_LOG2:0]   CNT_ONE = 1;

  logic [C_WIDTH-1:0]      mem_q [DEPTH];
  logic [C_DEPTH_LOG2-1:0] wr_ptr_q;
  logic [C_DEPTH_LOG2-1:0] rd_ptr_q;
  logic [C_DEPTH_LOG2:0]   count_q;
  logic                    do_push;
  logic                    do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  // The count only reaches its top bit when it equals DEPTH.
  assign full_o  = count_q[C_DEPTH_LOG2];
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/chnl_fifo_loopback.sv
// RIFFA channel tester: buffers RX beats in a FIFO and returns them on TX,
// either unchanged, with each lane incremented, or replaced by a word-index pattern.
module chnl_fifo_loopback
  import chnl_tester_pkg::*;
#(
  parameter int unsigned C_PCI_DATA_WIDTH  = 32,
  parameter int unsigned C_FIFO_DEPTH_LOG2 = 6
) (
  input  logic                        CLK,
  input  logic                        RST,
  output logic                        CHNL_RX_CLK,
  input  logic                        CHNL_RX,
  output logic                        CHNL_RX_ACK,
  input  logic                        CHNL_RX_LAST,
  input  logic [31:0]                 CHNL_RX_LEN,
  input  logic [30:0]                 CHNL_RX_OFF,
  input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
  input  logic                        CHNL_RX_DATA_VALID,
  output logic                        CHNL_RX_DATA_REN,
  output logic                        CHNL_TX_CLK,
  output logic                        CHNL_TX,
  input  logic                        CHNL_TX_ACK,
  output logic                        CHNL_TX_LAST,
  output logic [31:0]                 CHNL_TX_LEN,
  output logic [30:0]                 CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
  output logic                        CHNL_TX_DATA_VALID,
  input  logic                        CHNL_TX_DATA_REN,
  output logic [31:0]                 DONE_COUNT
);

  localparam int unsigned BEAT      = C_PCI_DATA_WIDTH / 32;
  localparam int unsigned BEAT_LOG2 = $clog2(BEAT);

  state_e      state_q;
  logic [31:0] len_q;
  logic [1:0]  mode_q;
  logic [31:0] nbeats_q;
  logic [31:0] nbeats_d;
  logic [31:0] rx_beats_q;
  logic [31:0] tx_beats_q;
  logic        ack_seen_q;
  logic        rx_ack_q;
  logic        tx_q;
  logic [31:0] done_q;

  logic        is_pat;
  logic        rx_more;
  logic        tx_more;
  logic        rx_ren;
  logic        tx_valid;
  logic        rx_fire;
  logic        tx_fire;
  logic        fifo_full;
  logic        fifo_empty;
  logic [C_PCI_DATA_WIDTH-1:0] fifo_dout;
  logic [C_PCI_DATA_WIDTH-1:0] push_data;
  logic [C_PCI_DATA_WIDTH-1:0] pat_data;
  logic        unused_ok;

  assign unused_ok = ^{CHNL_RX_LAST, CHNL_RX_OFF[30:2]};

  assign CHNL_RX_CLK  = CLK;
  assign CHNL_TX_CLK  = CLK;
  assign CHNL_TX_LAST = 1'b1;
  assign CHNL_TX_OFF  = '0;
  assign CHNL_RX_ACK  = rx_ack_q;
  assign CHNL_TX      = tx_q;
  assign CHNL_TX_LEN  = len_q;
  assign DONE_COUNT   = done_q;

  assign nbeats_d = beats_of(CHNL_RX_LEN, C_PCI_DATA_WIDTH);
  assign is_pat   = (mode_q == MODE_PAT);
  assign rx_more  = (rx_beats_q < nbeats_q);
  assign tx_more  = (tx_beats_q < nbeats_q);
  // Pattern mode never touches the FIFO, so neither full nor empty gates it.
  assign rx_ren   = (state_q == ST_RUN) & rx_more & (is_pat | ~fifo_full);
  assign tx_valid = (state_q == ST_RUN) & tx_more & ack_seen_q & (is_pat | ~fifo_empty);
  assign rx_fire  = rx_ren & CHNL_RX_DATA_VALID;
  assign tx_fire  = tx_valid & CHNL_TX_DATA_REN;

  assign CHNL_RX_DATA_REN   = rx_ren;
  assign CHNL_TX_DATA_VALID = tx_valid;
  assign CHNL_TX_DATA       = !tx_valid ? '0 : (is_pat ? pat_data : fifo_dout);

  always_comb begin
    push_data = CHNL_RX_DATA;
    pat_data  = '0;
    for (int unsigned k = 0; k < BEAT; k++) begin
      if (mode_q == MODE_INC) push_data[k*32 +: 32] = CHNL_RX_DATA[k*32 +: 32] + 32'd1;
      pat_data[k*32 +: 32] = (tx_beats_q << BEAT_LOG2) + 32'(k);
    end
  end

  riffa_sync_fifo #(
    .C_WIDTH      (C_PCI_DATA_WIDTH),
    .C_DEPTH_LOG2 (C_FIFO_DEPTH_LOG2)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push_i  (rx_fire & ~is_pat),
    .din_i   (push_data),
    .pop_i   (tx_fire & ~is_pat),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .dout_o  (fifo_dout)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      mode_q     <= MODE_LOOP;
      nbeats_q   <= '0;
      rx_beats_q <= '0;
      tx_beats_q <= '0;
      ack_seen_q <= 1'b0;
      rx_ack_q   <= 1'b0;
      tx_q       <= 1'b0;
      done_q     <= '0;
    end else begin
      rx_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (CHNL_RX) begin
            len_q      <= CHNL_RX_LEN;
            mode_q     <= CHNL_RX_OFF[1:0];
            nbeats_q   <= nbeats_d;
            rx_beats_q <= '0;
            tx_beats_q <= '0;
            ack_seen_q <= 1'b0;
            rx_ack_q   <= 1'b1;
            tx_q       <= 1'b1;
            state_q    <= ST_ACK;
          end
        end
        ST_ACK: begin
          // CHNL_TX is already visible here, so an immediate ack must count.
          if (CHNL_TX_ACK) ack_seen_q <= 1'b1;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (CHNL_TX_ACK) ack_seen_q <= 1'b1;
          if (rx_fire)     rx_beats_q <= rx_beats_q + 32'd1;
          if (tx_fire)     tx_beats_q <= tx_beats_q + 32'd1;
          if (!rx_more && !tx_more && ack_seen_q) begin
            tx_q    <= 1'b0;
            state_q <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          done_q  <= done_q + 32'd1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chnl_fifo_loopback.sv
// Bench for chnl_fifo_loopback: three instances (32-bit/depth 4, 64-bit/depth 64,
// 128-bit/depth 8) driven one at a time against a word-queue reference model.
module tb_chnl_fifo_loopback;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int          sel = 0;
  logic        rx = 1'b0, rx_valid = 1'b0, tx_ack = 1'b0, tx_ren = 1'b0;
  logic [31:0] rx_len = '0;
  logic [30:0] rx_off = '0;
  logic [127:0] rx_data = '0;

  logic         a_rx_ack [3];
  logic         a_rx_ren [3];
  logic         a_tx [3];
  logic         a_tx_valid [3];
  logic [127:0] a_txd [3];
  logic [31:0]  a_txlen [3];
  logic [31:0]  a_done [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 32 : (g == 1) ? 64 : 128;
    localparam int D = (g == 0) ? 2 : (g == 1) ? 6 : 3;
    logic         rx_clk, tx_clk, tx_last, rx_ack, rx_ren, tx, tx_valid;
    logic [30:0]  tx_off;
    logic [31:0]  tx_len, done;
    logic [W-1:0] txd;

    chnl_fifo_loopback #(.C_PCI_DATA_WIDTH(W), .C_FIFO_DEPTH_LOG2(D)) u_dut (
      .CLK                (CLK),
      .RST                (RST),
      .CHNL_RX_CLK        (rx_clk),
      .CHNL_RX            (rx && sel == g),
      .CHNL_RX_ACK        (rx_ack),
      .CHNL_RX_LAST       (1'b1),
      .CHNL_RX_LEN        (rx_len),
      .CHNL_RX_OFF        (rx_off),
      .CHNL_RX_DATA       (rx_data[W-1:0]),
      .CHNL_RX_DATA_VALID (rx_valid && sel == g),
      .CHNL_RX_DATA_REN   (rx_ren),
      .CHNL_TX_CLK        (tx_clk),
      .CHNL_TX            (tx),
      .CHNL_TX_ACK        (tx_ack && sel == g),
      .CHNL_TX_LAST       (tx_last),
      .CHNL_TX_LEN        (tx_len),
      .CHNL_TX_OFF        (tx_off),
      .CHNL_TX_DATA       (txd),
      .CHNL_TX_DATA_VALID (tx_valid),
      .CHNL_TX_DATA_REN   (tx_ren && sel == g),
      .DONE_COUNT         (done)
    );

    assign a_rx_ack[g]   = rx_ack;
    assign a_rx_ren[g]   = rx_ren;
    assign a_tx[g]       = tx;
    assign a_tx_valid[g] = tx_valid;
    assign a_txd[g]      = 128'(txd);
    assign a_txlen[g]    = tx_len;
    assign a_done[g]     = done;
  end

  int n_err = 0;
  int n_chk = 0;

  logic [31:0] in_words [$];
  logic [31:0] got_words [$];
  int          got_beats;
  int          hold_pushes;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (dut %0d, t=%0t)", name, act, exp, sel, $time);
    end
  endtask

  task automatic check_reset(input int s);
    check("rst_rx_ack", a_rx_ack[s], 0);
    check("rst_rx_ren", a_rx_ren[s], 0);
    check("rst_tx", a_tx[s], 0);
    check("rst_tx_valid", a_tx_valid[s], 0);
    check("rst_tx_data", a_txd[s], 0);
    check("rst_tx_len", a_txlen[s], 0);
    check("rst_done", a_done[s], 0);
  endtask

  // One host-side transaction; expected TX words come from the mode rules
  // applied to the words the host sends.
  task automatic run_txn(input int s, input int len, input int mode, input int ack_delay,
                         input int hold, input bit rnd);
    int beat = 1 << s;
    int nb   = (len + beat - 1) / beat;
    int nw   = nb * beat;
    logic [31:0] exp_w [$];
    logic [31:0] start_done;
    int rx_idx = 0, acks = 0, ack_wait = 0, cyc = 0, tx_cycles = 0;
    bit acked = 0, finished = 0, prev_stall = 0;
    logic [127:0] prev_d = '0;

    sel = s;
    while (in_words.size() < nw) in_words.push_back($urandom);
    for (int i = 0; i < nw; i++)
      exp_w.push_back(mode == 2 ? 32'(i) : mode == 1 ? in_words[i] + 32'd1 : in_words[i]);
    got_words.delete();
    got_beats   = 0;
    hold_pushes = 0;

    @(negedge CLK);
    start_done = a_done[s];
    rx     = 1'b1;
    rx_len = 32'(len);
    rx_off = 31'(mode);
    while (!finished && cyc < 3000) begin
      if (a_rx_ack[s]) begin
        acks++;
        rx = 1'b0;
      end
      if (a_done[s] !== start_done) begin
        finished = 1;
      end else begin
        tx_ack = 1'b0;
        if (a_tx[s] && !acked) begin
          if (ack_wait == ack_delay) begin
            tx_ack = 1'b1;
            acked  = 1;
          end else ack_wait++;
        end
        rx_valid = (rx_idx < nb) && (!rnd || $urandom_range(0, 1) == 1);
        rx_data  = '0;
        if (rx_idx < nb)
          for (int k = 0; k < beat; k++) rx_data[k*32 +: 32] = in_words[rx_idx*beat + k];
        tx_ren = (cyc >= hold) && (!rnd || $urandom_range(0, 3) != 0);
        #1;
        if (prev_stall) begin
          check("tx_stall_valid", a_tx_valid[s], 1);
          check("tx_stall_data", a_txd[s], prev_d);
        end
        prev_stall = a_tx_valid[s] && !tx_ren;
        prev_d     = a_txd[s];
        if (rx_valid && a_rx_ren[s]) begin
          rx_idx++;
          if (cyc < hold) hold_pushes++;
        end
        if (a_tx_valid[s] && tx_ren) begin
          got_beats++;
          for (int k = 0; k < beat; k++) got_words.push_back(a_txd[s][k*32 +: 32]);
        end
        if (a_tx[s]) tx_cycles++;
        cyc++;
        @(negedge CLK);
      end
    end
    rx = 1'b0; rx_valid = 1'b0; tx_ack = 1'b0; tx_ren = 1'b0;

    check("txn_completes", finished, 1);
    check("done_inc", a_done[s], start_done + 32'd1);
    check("rx_ack_pulses", acks, 1);
    check("tx_beats", got_beats, nb);
    check("tx_len", a_txlen[s], len);
    check("tx_held_to_ack", tx_cycles > ack_delay, 1);
    for (int i = 0; i < nw && i < got_words.size(); i++) check("tx_word", got_words[i], exp_w[i]);
    in_words.delete();
  endtask

  typedef struct {
    int          s;
    int          len;
    int          mode;
    int          ack_delay;
    int          exp_beats;
    logic [31:0] w0;
    logic [31:0] exp_w0;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int pushes;

    tbl[0] = '{0,  8, 0, 0, 8, 32'h12345678, 32'h12345678};
    tbl[1] = '{1,  5, 1, 2, 3, 32'hFFFFFFFF, 32'h00000000};
    tbl[2] = '{2, 12, 2, 1, 3, 32'hAAAA5555, 32'h00000000};
    tbl[3] = '{2,  5, 0, 0, 2, 32'hCAFEF00D, 32'hCAFEF00D};
    tbl[4] = '{0,  3, 3, 0, 3, 32'h00000007, 32'h00000007};
    tbl[5] = '{1,  0, 0, 6, 0, 32'h00000000, 32'h00000000};

    repeat (3) @(negedge CLK);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      check_reset(s);
    end
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 6; i++) begin
      in_words.delete();
      in_words.push_back(tbl[i].w0);
      run_txn(tbl[i].s, tbl[i].len, tbl[i].mode, tbl[i].ack_delay, 0, 0);
      check("tbl_beats", got_beats, tbl[i].exp_beats);
      if (got_words.size() > 0) check("tbl_word0", got_words[0], tbl[i].exp_w0);
    end

    // Backpressure on the depth-4 instance: only four beats fit while TX is stalled.
    run_txn(0, 16, 0, 0, 20, 0);
    check("bp_pushes_while_stalled", hold_pushes, 4);

    // Reset in the middle of RUN with three beats buffered.
    sel = 0;
    @(negedge CLK);
    rx = 1'b1; rx_len = 32'd8; rx_off = '0; tx_ren = 1'b0; rx_valid = 1'b0;
    for (int i = 0; i < 20 && !a_rx_ack[0]; i++) @(negedge CLK);
    check("mr_rx_ack", a_rx_ack[0], 1);
    rx = 1'b0;
    pushes = 0;
    for (int i = 0; i < 20 && pushes < 3; i++) begin
      rx_valid = 1'b1;
      rx_data  = 128'($urandom);
      #1;
      if (a_rx_ren[0]) pushes++;
      @(negedge CLK);
    end
    rx_valid = 1'b0;
    check("mr_pushes", pushes, 3);
    check("mr_tx_before_rst", a_tx[0], 1);
    RST = 1'b1;
    #1;
    check_reset(0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    run_txn(0, 4, 0, 0, 0, 0);
    check("mr_fresh_beats", got_beats, 4);
    check("mr_done_after", a_done[0], 1);

    for (int i = 0; i < 40; i++)
      run_txn($urandom_range(0, 2), $urandom_range(0, 40), $urandom_range(0, 3),
              $urandom_range(0, 3), 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/chnl_fifo_loopback.md
Name: chnl_fifo_loopback

Overview:
- Parametrised RIFFA channel tester; successor to the single-register loopback tester.
- Buffers received beats in an internal FIFO, so RX and TX overlap without lockstep throttling.
- Data width is generalised to 32/64/128, and FIFO depth is configurable.
- Three per-transaction modes (loopback, increment, pattern) are selected by CHNL_RX_OFF. Sits on one RIFFA channel behind the PCIe endpoint.

Parameters:
- C_PCI_DATA_WIDTH, 32, channel data width; legal values 32, 64, 128.
- C_FIFO_DEPTH_LOG2, 6, FIFO holds 2**C_FIFO_DEPTH_LOG2 beats.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- CHNL_RX_CLK  out  1  driven by CLK.
- CHNL_RX  in  1  RX transaction request.
- CHNL_RX_ACK  out  1  one-cycle RX accept pulse.
- CHNL_RX_LAST  in  1  ignored.
- CHNL_RX_LEN  in  32  RX length in 32-bit words.
- CHNL_RX_OFF  in  31  bits [1:0] select mode; other bits ignored.
- CHNL_RX_DATA  in  W  RX beat.
- CHNL_RX_DATA_VALID  in  1  RX beat valid.
- CHNL_RX_DATA_REN  out  1  RX beat accept.
- CHNL_TX_CLK  out  1  driven by CLK.
- CHNL_TX  out  1  TX transaction request.
- CHNL_TX_ACK  in  1  TX request acknowledged by host side.
- CHNL_TX_LAST  out  1  constant 1.
- CHNL_TX_LEN  out  32  latched RX length.
- CHNL_TX_OFF  out  31  constant 0.
- CHNL_TX_DATA  out  W  TX beat.
- CHNL_TX_DATA_VALID  out  1  TX beat valid.
- CHNL_TX_DATA_REN  in  1  TX beat accept.
- DONE_COUNT  out  32  completed transactions; wraps modulo 2**32.

Behaviour:
- Definitions:
  - BEAT = W/32 words.
  - nbeats = (len + BEAT-1) >> log2(BEAT), 32-bit unsigned.
  - An RX beat transfers when VALID & REN; a TX beat transfers when VALID & REN.
- Reset (any cycle, including mid-transaction):
  - FSM goes to IDLE and the FIFO is flushed.
  - CHNL_RX_ACK, CHNL_RX_DATA_REN, CHNL_TX and CHNL_TX_DATA_VALID are 0.
  - CHNL_TX_DATA = 0, CHNL_TX_LEN = 0, DONE_COUNT = 0.
- FSM states: IDLE, ACK, RUN, FINISH.
- IDLE: when CHNL_RX = 1, latch len, mode and nbeats, clear rx_beats, tx_beats and ack_seen, then go to ACK.
- ACK: CHNL_RX_ACK = 1 for exactly this cycle; CHNL_TX asserts from this cycle. Go to RUN.
- RUN:
  - CHNL_RX_DATA_REN = (rx_beats < nbeats) & FIFO not full. Full blocks a push even if a pop occurs in the same cycle.
  - Mode 1 (increment): each 32-bit lane is pushed +1, modulo 2**32.
  - Mode 2 (pattern): RX beats are accepted and discarded, no FIFO push, same REN rule minus the full term.
  - ack_seen is set on CHNL_TX_ACK.
  - TX valid = (tx_beats < nbeats) & ack_seen & (FIFO not empty, or mode 2).
  - Mode 2 TX data: lane k of beat b = b*BEAT+k, as a 32-bit word index.
  - Modes 0 (loopback) and 3 (reserved) push data unchanged.
  - Leave RUN when rx_beats = nbeats, tx_beats = nbeats and ack_seen.
- FINISH: CHNL_TX = 0, DONE_COUNT + 1, go to IDLE.
- len = 0:
  - nbeats = 0, no data beats.
  - CHNL_TX held until CHNL_TX_ACK, then FINISH.
- Partial final beat: the beat is still a full beat; unused upper lanes are passed through (loopback) or carry pattern values.
- FIFO:
  - First-word-fall-through.
  - A push in cycle N is visible on CHNL_TX_DATA in cycle N+1 at the earliest.
  - Simultaneous push and pop are allowed when not full.
  - Pointers wrap at depth.
- Beats are never dropped or duplicated. CHNL_TX_DATA is held stable while VALID & !REN.
- CHNL_RX asserted outside IDLE is ignored until the FSM returns to IDLE.

Decomposition:
- Package chnl_tester_pkg holds:
  - Mode constants MODE_LOOP = 0, MODE_INC = 1, MODE_PAT = 2.
  - FSM state encoding.
  - Function beats_of(len, width).
- One sub-module, riffa_sync_fifo:
  - Parameters: width, depth log2.
  - Ports: push, pop, full, empty, dout (first-word-fall-through).
  - Async active-high reset.

Test Plan:
- W=32, mode 0, len=8, REN always 1 -> TX carries words 0..7 in order; DONE_COUNT=1; RX_ACK high exactly 1 cycle.
- W=64, mode 1, len=5 (3 beats), data 0xFFFFFFFF in lane 0 -> TX lane 0 = 0x00000000; 3 TX beats; CHNL_TX_LEN=5.
- W=32, depth 4, len=16, TX REN held 0 for 20 cycles -> RX_DATA_REN drops after 4 pushes; all 16 words then delivered without loss or duplication.
- W=128, mode 2, len=12 -> 3 TX beats; beat 1 lanes = 4,5,6,7; RX data discarded.
- len=0 -> RX_ACK pulses, CHNL_TX held until TX_ACK, no data valid, DONE_COUNT increments.
- RST asserted mid-RUN with 3 beats buffered -> all outputs and DONE_COUNT 0 next cycle; a following len=4 transaction returns exactly 4 fresh words.
